// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: parametrised AXI4-Stream buffer with first-word
// fall-through output and an optional store-and-forward packet mode.
// In packet mode a packet is only offered downstream once its tlast word
// is stored, unless it is too large to fit, in which case it drains
// cut-through and the sticky oversize flag is raised.
module axis_packet_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                s00_axis_aclk,
  input  logic                s00_axis_areset,
  input  logic [DATA_W-1:0]   s00_axis_tdata,
  input  logic [DATA_W/8-1:0] s00_axis_tstrb,
  input  logic                s00_axis_tlast,
  input  logic                s00_axis_tvalid,
  output logic                s00_axis_tready,
  output logic [DATA_W-1:0]   m00_axis_tdata,
  output logic [DATA_W/8-1:0] m00_axis_tstrb,
  output logic                m00_axis_tlast,
  output logic                m00_axis_tvalid,
  input  logic                m00_axis_tready,
  output logic [ADDR_W:0]     fill_level,
  output logic [ADDR_W:0]     pkt_count,
  output logic                oversize
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + STRB_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr_next;
  logic [ADDR_W:0] rd_ptr_next;
  logic [ADDR_W:0] fill_next;
  logic [ADDR_W:0] pkt_next;
  logic [ADDR_W:0] pkt_q;
  logic            in_ready_q;
  logic            release_q;
  logic            oversize_q;
  logic            wr_en;
  logic            rd_en;
  logic            out_valid;
  logic            wr_last;
  logic            rd_last;

  assign wr_en   = s00_axis_tvalid && in_ready_q;
  assign rd_en   = out_valid && m00_axis_tready;
  assign wr_last = wr_en && s00_axis_tlast;
  assign rd_last = rd_en && m00_axis_tlast;

  assign {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = mem[rd_ptr[ADDR_W-1:0]];

  assign fill_level      = wr_ptr - rd_ptr;
  assign pkt_count       = pkt_q;
  assign oversize        = oversize_q;
  assign s00_axis_tready = in_ready_q;
  assign m00_axis_tvalid = out_valid;

  // Output valid: plain non-empty in cut-through mode; in packet mode a whole
  // packet must be held, or an oversize packet must have been released.
  always_comb begin
    out_valid = (fill_level != '0);
    if (PACKET_MODE != 0) begin
      out_valid = (fill_level != '0) && ((pkt_q != '0) || release_q);
    end
  end

  // Next pointer, occupancy and packet-count values for this cycle's handshakes.
  always_comb begin
    wr_ptr_next = wr_ptr + (ADDR_W + 1)'(wr_en);
    rd_ptr_next = rd_ptr + (ADDR_W + 1)'(rd_en);
    fill_next   = wr_ptr_next - rd_ptr_next;
    pkt_next    = pkt_q;
    if (wr_last && !rd_last) begin
      pkt_next = pkt_q + 1'b1;
    end else if (rd_last && !wr_last) begin
      pkt_next = pkt_q - 1'b1;
    end
  end

  // Pointer, packet-count and registered input-ready state.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      pkt_q      <= pkt_next;
      in_ready_q <= (fill_next < DEPTH_L);
    end
  end

  // Release a full buffer holding no complete packet so it cannot deadlock;
  // the release ends when that packet's tlast word leaves.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      release_q  <= 1'b0;
      oversize_q <= 1'b0;
    end else if ((PACKET_MODE != 0) && (fill_next == DEPTH_L) && (pkt_next == '0)) begin
      release_q  <= 1'b1;
      oversize_q <= 1'b1;
    end else if (rd_last) begin
      release_q  <= 1'b0;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge s00_axis_aclk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: directed self-checking bench for axis_packet_fifo.
// One instance runs in packet mode, a second in cut-through mode.
module tb_axis_packet_fifo;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst;

  logic [DATA_W-1:0] p_s_tdata, p_m_tdata, c_s_tdata, c_m_tdata;
  logic [STRB_W-1:0] p_s_tstrb, p_m_tstrb, c_s_tstrb, c_m_tstrb;
  logic p_s_tlast, p_s_tvalid, p_s_tready, p_m_tlast, p_m_tvalid, p_m_tready;
  logic c_s_tlast, c_s_tvalid, c_s_tready, c_m_tlast, c_m_tvalid, c_m_tready;
  logic [CNT_W-1:0] p_fill, p_pkt, c_fill, c_pkt;
  logic p_oversize, c_oversize;

  int checks = 0;
  int errors = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  axis_packet_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACKET_MODE(1)) dut_pkt (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tdata(p_s_tdata), .s00_axis_tstrb(p_s_tstrb), .s00_axis_tlast(p_s_tlast),
    .s00_axis_tvalid(p_s_tvalid), .s00_axis_tready(p_s_tready),
    .m00_axis_tdata(p_m_tdata), .m00_axis_tstrb(p_m_tstrb), .m00_axis_tlast(p_m_tlast),
    .m00_axis_tvalid(p_m_tvalid), .m00_axis_tready(p_m_tready),
    .fill_level(p_fill), .pkt_count(p_pkt), .oversize(p_oversize)
  );

  axis_packet_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACKET_MODE(0)) dut_ct (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tdata(c_s_tdata), .s00_axis_tstrb(c_s_tstrb), .s00_axis_tlast(c_s_tlast),
    .s00_axis_tvalid(c_s_tvalid), .s00_axis_tready(c_s_tready),
    .m00_axis_tdata(c_m_tdata), .m00_axis_tstrb(c_m_tstrb), .m00_axis_tlast(c_m_tlast),
    .m00_axis_tvalid(c_m_tvalid), .m00_axis_tready(c_m_tready),
    .fill_level(c_fill), .pkt_count(c_pkt), .oversize(c_oversize)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input int data, input bit last);
    p_s_tvalid = valid;
    p_s_tdata  = data;
    p_s_tstrb  = 4'(data);
    p_s_tlast  = last;
  endtask

  // Sends an n-word packet base..base+n-1 into the packet-mode FIFO while the
  // sink is ready and checks every word, strobe and tlast leaving it.
  task automatic runPacket(input int n, input int base, input bit big);
    int sent = 0;
    int rcv  = 0;
    int cyc  = 0;
    bit w_acc;
    bit r_acc;
    applyStimulus(1'b1, base, n == 1);
    while (rcv < n && cyc < 400) begin
      w_acc = p_s_tvalid && p_s_tready;
      r_acc = p_m_tvalid && p_m_tready;
      if (r_acc) begin
        if (big && rcv == 0) begin
          checkOutput("ovs_fill_at_start", 64'(p_fill), 64'(DEPTH));
          checkOutput("ovs_flag_at_start", 64'(p_oversize), 64'd1);
        end
        checkOutput("pkt_data", 64'(p_m_tdata), 64'(base + rcv));
        checkOutput("pkt_strb", 64'(p_m_tstrb), 64'((base + rcv) & 15));
        checkOutput("pkt_last", 64'(p_m_tlast), 64'(rcv == n - 1));
        rcv++;
      end
      step();
      cyc++;
      if (w_acc) begin
        sent++;
        if (sent < n) applyStimulus(1'b1, base + sent, sent == n - 1);
        else applyStimulus(1'b0, 0, 1'b0);
      end
    end
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("pkt_words_received", 64'(rcv), 64'(n));
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    p_m_tready = 1'b0;
    c_s_tvalid = 1'b0; c_s_tdata = '0; c_s_tstrb = '0; c_s_tlast = 1'b0;
    c_m_tready = 1'b0;
    repeat (2) step();

    checkOutput("rst_tready", 64'(p_s_tready), 64'd0);
    checkOutput("rst_tvalid", 64'(p_m_tvalid), 64'd0);
    checkOutput("rst_fill", 64'(p_fill), 64'd0);
    checkOutput("rst_pkt", 64'(p_pkt), 64'd0);
    checkOutput("rst_oversize", 64'(p_oversize), 64'd0);
    checkOutput("rst_ct_tready", 64'(c_s_tready), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_tready", 64'(p_s_tready), 64'd1);
    checkOutput("post_rst_ct_tready", 64'(c_s_tready), 64'd1);

    // Store-and-forward: nothing leaves until tlast is stored.
    p_m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i, i == 3);
      step();
      if (i < 3) checkOutput("sf_hold_tvalid", 64'(p_m_tvalid), 64'd0);
    end
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("sf_tvalid", 64'(p_m_tvalid), 64'd1);
    checkOutput("sf_pkt_one", 64'(p_pkt), 64'd1);
    checkOutput("sf_fill", 64'(p_fill), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sf_out_valid", 64'(p_m_tvalid), 64'd1);
      checkOutput("sf_out_data", 64'(p_m_tdata), 64'(i));
      checkOutput("sf_out_last", 64'(p_m_tlast), 64'(i == 3));
      step();
    end
    checkOutput("sf_done_tvalid", 64'(p_m_tvalid), 64'd0);
    checkOutput("sf_done_pkt", 64'(p_pkt), 64'd0);

    // Fill with sixteen single-word packets while the sink stalls.
    p_m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("fill_tready_open", 64'(p_s_tready), 64'd1);
      applyStimulus(1'b1, 100 + i, 1'b1);
      step();
    end
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("full_tready", 64'(p_s_tready), 64'd0);
    checkOutput("full_fill", 64'(p_fill), 64'd16);
    checkOutput("full_pkt", 64'(p_pkt), 64'd16);
    checkOutput("full_head", 64'(p_m_tdata), 64'd100);
    p_m_tready = 1'b1;
    step();
    p_m_tready = 1'b0;
    checkOutput("one_read_fill", 64'(p_fill), 64'd15);
    checkOutput("one_read_pkt", 64'(p_pkt), 64'd15);
    checkOutput("one_read_tready", 64'(p_s_tready), 64'd1);
    p_m_tready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      checkOutput("drain_data", 64'(p_m_tdata), 64'(101 + k));
      step();
    end
    checkOutput("drain_fill", 64'(p_fill), 64'd0);
    checkOutput("drain_oversize", 64'(p_oversize), 64'd0);

    // Oversize 20-word packet into a 16-entry buffer.
    runPacket(20, 200, 1'b1);
    checkOutput("ovs_sticky", 64'(p_oversize), 64'd1);
    checkOutput("ovs_fill_end", 64'(p_fill), 64'd0);

    // Simultaneous read and write at fill level 8.
    p_m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 300 + i, 1'b1);
      step();
    end
    p_m_tready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 308 + j, 1'b1);
      checkOutput("sim_data", 64'(p_m_tdata), 64'(300 + j));
      step();
      checkOutput("sim_fill", 64'(p_fill), 64'd8);
      checkOutput("sim_pkt", 64'(p_pkt), 64'd8);
    end
    applyStimulus(1'b0, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("sim_drain", 64'(p_m_tdata), 64'(310 + k));
      step();
    end
    checkOutput("sim_empty", 64'(p_m_tvalid), 64'd0);

    // Reset mid-packet with five unfinished words stored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 400 + i, 1'b0);
      step();
    end
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("mid_fill", 64'(p_fill), 64'd5);
    checkOutput("mid_hold", 64'(p_m_tvalid), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_fill", 64'(p_fill), 64'd0);
    checkOutput("async_rst_pkt", 64'(p_pkt), 64'd0);
    checkOutput("async_rst_tvalid", 64'(p_m_tvalid), 64'd0);
    checkOutput("async_rst_oversize", 64'(p_oversize), 64'd0);
    #1;
    rst = 1'b0;
    step();
    checkOutput("rerelease_tready", 64'(p_s_tready), 64'd1);
    runPacket(2, 500, 1'b0);
    checkOutput("after_rst_fill", 64'(p_fill), 64'd0);
    checkOutput("after_rst_tvalid", 64'(p_m_tvalid), 64'd0);

    // Cut-through: 32 words with a gap every fourth cycle, one-cycle latency.
    c_m_tready = 1'b1;
    begin
      int idx = 0;
      int cyc = 0;
      bit w_acc;
      while (idx < 32 && cyc < 100) begin
        c_s_tvalid = (cyc % 4) != 3;
        c_s_tdata  = idx;
        c_s_tstrb  = 4'(idx);
        c_s_tlast  = (idx == 31);
        w_acc = c_s_tvalid && c_s_tready;
        step();
        cyc++;
        if (w_acc) begin
          checkOutput("ct_valid", 64'(c_m_tvalid), 64'd1);
          checkOutput("ct_data", 64'(c_m_tdata), 64'(idx));
          checkOutput("ct_strb", 64'(c_m_tstrb), 64'(idx & 15));
          checkOutput("ct_fill_le2", 64'(c_fill <= 2), 64'd1);
          idx++;
        end else begin
          checkOutput("ct_gap_valid", 64'(c_m_tvalid), 64'd0);
        end
      end
      c_s_tvalid = 1'b0;
      checkOutput("ct_words_sent", 64'(idx), 64'd32);
      step();
      checkOutput("ct_empty", 64'(c_fill), 64'd0);
      checkOutput("ct_oversize", 64'(c_oversize), 64'd0);
      checkOutput("ct_pkt", 64'(c_pkt), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
